// File: rtl/jtframe_romrq_2way.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtframe_romrq_2way : CPU ROM request slot with a 2-entry 32-bit word cache |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module jtframe_romrq_2way #(
  parameter int AW = 17,
  parameter int DW = 8,
  parameter int SW = (DW == 8) ? AW - 2 : AW - 1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          flush,
  output logic [DW-1:0] dout,
  output logic          ok,
  output logic          sdram_req,
  output logic [SW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [31:0]   din
);

  localparam int SUBW = (DW == 8) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [SW-1:0]   r_addr;
  logic [1:0]      r_valid;
  logic [SW-1:0]   r_tag [2];
  logic [31:0]     r_data [2];
  logic            r_lru;
  logic            r_discard;

  logic [SW-1:0]   w_wa;
  logic [SUBW-1:0] w_sub;
  logic [1:0]      w_hit;
  logic            w_hit_any;
  logic [31:0]     w_word;
  logic [31:0]     w_lane;
  logic [4:0]      w_shamt;
  logic            w_start;
  logic            w_fill;

  assign w_wa  = addr[AW-1:AW-SW];
  assign w_sub = addr[SUBW-1:0];

  // flush masks the hit immediately so ok drops in the same cycle
  assign w_hit[0]  = r_valid[0] && (r_tag[0] == w_wa) && !flush;
  assign w_hit[1]  = r_valid[1] && (r_tag[1] == w_wa) && !flush;
  assign w_hit_any = w_hit[0] | w_hit[1];

  generate
    if (DW == 8) begin : g_lane8
      assign w_shamt = {w_sub, 3'b000};
    end else begin : g_lane16
      assign w_shamt = {w_sub, 4'b0000};
    end
  endgenerate

  assign w_word     = w_hit[1] ? r_data[1] : r_data[0];
  assign w_lane     = w_word >> w_shamt;
  assign dout       = w_hit_any ? w_lane[DW-1:0] : '0;
  assign ok         = cs && w_hit_any;
  assign sdram_addr = r_addr;

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_fill     = 1'b0;
    sdram_req  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cs && !w_hit_any && !flush) begin
          w_start    = 1'b1;
          w_state_nx = REQ;
        end
      end
      REQ: begin
        sdram_req = 1'b1;
        if (sdram_ack) begin
          if (data_rdy) begin
            w_fill     = 1'b1;
            w_state_nx = IDLE;
          end else begin
            w_state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (data_rdy) begin
          w_fill     = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_valid   <= '0;
      r_tag     <= '{default: '0};
      r_data    <= '{default: '0};
      r_lru     <= 1'b0;
      r_discard <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_start) r_addr <= w_wa;
      if (w_fill) begin
        r_tag[r_lru]  <= r_addr;
        r_data[r_lru] <= din;
      end
      // a discarded or flushed fill still completes the handshake but stays invalid
      if (flush) begin
        r_valid <= '0;
      end else if (w_fill && !r_discard) begin
        r_valid[r_lru] <= 1'b1;
      end
      if (w_fill && !flush && !r_discard) begin
        r_lru <= ~r_lru;
      end else if (cs && w_hit[0]) begin
        r_lru <= 1'b1;
      end else if (cs && w_hit[1]) begin
        r_lru <= 1'b0;
      end
      if (w_state_nx == IDLE) begin
        r_discard <= 1'b0;
      end else if (flush && r_state != IDLE) begin
        r_discard <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_romrq_2way.sv
`default_nettype none
// Directed bench for jtframe_romrq_2way: one DW=8 and one DW=16 instance.
module tb_jtframe_romrq_2way;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        cs = 1'b0, flush = 1'b0, ack = 1'b0, rdy = 1'b0;
  logic [16:0] addr = '0;
  logic [31:0] din = '0;
  logic [7:0]  dout8;
  logic        ok8, req8;
  logic [14:0] saddr8;

  logic        cs16 = 1'b0, flush16 = 1'b0, ack16 = 1'b0, rdy16 = 1'b0;
  logic [16:0] addr16 = '0;
  logic [31:0] din16 = '0;
  logic [15:0] dout16;
  logic        ok16, req16;
  logic [15:0] saddr16;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  jtframe_romrq_2way #(.AW(17), .DW(8)) u8 (
    .clk(clk), .rst(rst), .cs(cs), .addr(addr), .flush(flush),
    .dout(dout8), .ok(ok8), .sdram_req(req8), .sdram_addr(saddr8),
    .sdram_ack(ack), .data_rdy(rdy), .din(din)
  );

  jtframe_romrq_2way #(.AW(17), .DW(16)) u16 (
    .clk(clk), .rst(rst), .cs(cs16), .addr(addr16), .flush(flush16),
    .dout(dout16), .ok(ok16), .sdram_req(req16), .sdram_addr(saddr16),
    .sdram_ack(ack16), .data_rdy(rdy16), .din(din16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // waits (bounded) for a request, checks its address, then acks and returns word
  task automatic serve(input string tag, input logic [14:0] exp_wa, input logic [31:0] word);
    int n = 0;
    while (!req8 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(req8), 32'd1);
    check({tag, "_saddr"}, 32'(saddr8), 32'(exp_wa));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    #1;
    check({tag, "_req_drop"}, 32'(req8), 32'd0);
    rdy = 1'b1;
    din = word;
    tick();
    rdy = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    #1;
    check("rst_ok", 32'(ok8), 32'd0);
    check("rst_dout", 32'(dout8), 32'd0);
    check("rst_req", 32'(req8), 32'd0);
    check("rst_saddr", 32'(saddr8), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // cold miss with cycle-exact handshake
    tick();
    cs = 1'b1;
    addr = 17'h00005;
    #1;
    check("c0_ok", 32'(ok8), 32'd0);
    check("c0_req", 32'(req8), 32'd0);
    tick();
    check("c1_req", 32'(req8), 32'd1);
    check("c1_saddr", 32'(saddr8), 32'h1);
    tick();
    tick();
    ack = 1'b1;
    #1;
    check("c3_req", 32'(req8), 32'd1);
    tick();
    ack = 1'b0;
    #1;
    check("c4_req", 32'(req8), 32'd0);
    tick();
    tick();
    rdy = 1'b1;
    din = 32'hDDCCBBAA;
    #1;
    check("c6_ok", 32'(ok8), 32'd0);
    tick();
    rdy = 1'b0;
    #1;
    check("c7_ok", 32'(ok8), 32'd1);
    check("c7_dout", 32'(dout8), 32'hBB);
    addr = 17'h00007;
    #1;
    check("c7_ok_b3", 32'(ok8), 32'd1);
    check("c7_dout_b3", 32'(dout8), 32'hDD);

    // two-way retention: word 2 filled, word 1 touched, word 3 evicts word 2
    addr = 17'h00008;
    #1;
    check("w2_miss", 32'(ok8), 32'd0);
    tick();
    serve("w2", 15'h2, 32'h44332211);
    check("w2_ok", 32'(ok8), 32'd1);
    check("w2_dout", 32'(dout8), 32'h11);
    addr = 17'h00004;
    #1;
    check("w1_hit", 32'(ok8), 32'd1);
    check("w1_dout", 32'(dout8), 32'hAA);
    tick();
    addr = 17'h0000C;
    tick();
    serve("w3", 15'h3, 32'h88776655);
    addr = 17'h0000D;
    #1;
    check("w3_dout", 32'(dout8), 32'h66);
    addr = 17'h00006;
    #1;
    check("w1_kept_ok", 32'(ok8), 32'd1);
    check("w1_kept_dout", 32'(dout8), 32'hCC);
    tick();
    check("w1_kept_noreq", 32'(req8), 32'd0);
    addr = 17'h00008;
    #1;
    check("w2_evicted", 32'(ok8), 32'd0);
    cs = 1'b0;

    // address moves while in WAIT
    tick();
    cs = 1'b1;
    addr = 17'h00040;
    tick();
    check("mv_saddr", 32'(saddr8), 32'h10);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    addr = 17'h00080;
    #1;
    check("mv_wait_ok", 32'(ok8), 32'd0);
    tick();
    rdy = 1'b1;
    din = 32'h0A0B0C0D;
    tick();
    rdy = 1'b0;
    #1;
    check("mv_idle_ok", 32'(ok8), 32'd0);
    check("mv_idle_req", 32'(req8), 32'd0);
    tick();
    check("mv_req2", 32'(req8), 32'd1);
    serve("mv2", 15'h20, 32'h5A5B5C5D);
    check("mv2_ok", 32'(ok8), 32'd1);
    check("mv2_dout", 32'(dout8), 32'h5D);
    addr = 17'h00041;
    #1;
    check("mv1_dout", 32'(dout8), 32'h0C);

    // flush in IDLE drops ok in the same cycle
    flush = 1'b1;
    #1;
    check("fl_same_cycle", 32'(ok8), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_invalid", 32'(ok8), 32'd0);
    cs = 1'b0;

    // flush during WAIT: fill is discarded and the access re-requests
    tick();
    cs = 1'b1;
    addr = 17'h00100;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rdy = 1'b1;
    din = 32'hFFFFFFFF;
    tick();
    rdy = 1'b0;
    #1;
    check("fw_ok", 32'(ok8), 32'd0);
    tick();
    check("fw_rereq", 32'(req8), 32'd1);
    check("fw_saddr", 32'(saddr8), 32'h40);
    serve("fw", 15'h40, 32'h13572468);
    check("fw_dout", 32'(dout8), 32'h68);

    // async reset in REQ drops sdram_req at once
    addr = 17'h00300;
    tick();
    check("rq_req", 32'(req8), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rq_rst_req", 32'(req8), 32'd0);
    rst = 1'b0;

    // async reset in WAIT while another word hits
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    addr = 17'h00300;
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    addr = 17'h00301;
    #1;
    check("ar_wait_miss", 32'(ok8), 32'd0);
    rdy = 1'b1;
    din = 32'h11223344;
    tick();
    rdy = 1'b0;
    addr = 17'h00200;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    addr = 17'h00301;
    #1;
    check("ar_hit_in_wait", 32'(ok8), 32'd1);
    check("ar_hit_dout", 32'(dout8), 32'h33);
    #2 rst = 1'b1;
    #1;
    check("ar_rst_ok", 32'(ok8), 32'd0);
    check("ar_rst_req", 32'(req8), 32'd0);
    check("ar_rst_dout", 32'(dout8), 32'd0);
    rst = 1'b0;
    cs = 1'b0;
    tick();
    rdy = 1'b1;
    din = 32'hDEADBEEF;
    tick();
    rdy = 1'b0;
    cs = 1'b1;
    addr = 17'h00200;
    #1;
    check("ar_late_rdy_ok", 32'(ok8), 32'd0);
    tick();
    check("ar_rereq", 32'(req8), 32'd1);
    check("ar_saddr", 32'(saddr8), 32'h80);
    serve("ar", 15'h80, 32'h99887766);
    check("ar_dout", 32'(dout8), 32'h66);
    cs = 1'b0;

    // DW=16: acknowledge and data in the same cycle
    cs16 = 1'b1;
    addr16 = 17'h00021;
    #1;
    check("h_miss", 32'(ok16), 32'd0);
    tick();
    check("h_req", 32'(req16), 32'd1);
    check("h_saddr", 32'(saddr16), 32'h10);
    ack16 = 1'b1;
    rdy16 = 1'b1;
    din16 = 32'hCAFE1234;
    tick();
    ack16 = 1'b0;
    rdy16 = 1'b0;
    #1;
    check("h_ok", 32'(ok16), 32'd1);
    check("h_dout_hi", 32'(dout16), 32'hCAFE);
    check("h_req_low", 32'(req16), 32'd0);
    tick();
    check("h_idle_req", 32'(req16), 32'd0);
    addr16 = 17'h00020;
    #1;
    check("h_dout_lo", 32'(dout16), 32'h1234);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
